eth_intr_coalescer: RTL and testbench



---
 rtl/eth_intr_pkg.sv | 23 ++
 rtl/eth_intr_channel.sv | 162 ++++++++++++++++
 rtl/eth_intr_coalescer.sv | 59 +++++
 tb/tb_eth_intr_coalescer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_intr_pkg.sv
// rtl/eth_intr_pkg.sv - shared state/register-select encodings and reset defaults for the interrupt coalescer
package eth_intr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COALESCE,
      PENDING
   } eth_intr_state_e;

   typedef enum logic [1:0] {
      ENABLE,
      MODE,
      THRESHOLD,
      TIMEOUT
   } eth_intr_cfg_sel_e;

   localparam logic enable_rst_lp    = 1'b0;
   localparam logic mode_rst_lp      = 1'b0;  // level mode
   localparam int   threshold_rst_lp = 1;
   localparam int   timeout_rst_lp   = 0;     // timeout disabled
   localparam int   stat_width_lp    = 32;

endpackage

// File: rtl/eth_intr_channel.sv
// rtl/eth_intr_channel.sv - one interrupt source: config regs, level/edge coalescing FSM, counters
// Optional ETH_INTR_STATS_EN adds a saturating count of pending rising edges.
module eth_intr_channel
   import eth_intr_pkg::*;
#(
   parameter int count_width_p = 8,
   parameter int timer_width_p = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     src_i,
   input  logic                     cfg_we_i,
   input  logic [1:0]               cfg_sel_i,
   input  logic [timer_width_p-1:0] cfg_data_i,
   input  logic                     clear_i,
   output logic                     pending_o,
   output logic                     pending_nxt_o,
   output logic [stat_width_lp-1:0] stat_count_o
);

   eth_intr_cfg_sel_e          cfg_sel;
   logic                       enable_q, enable_d;
   logic                       mode_q, mode_d;
   logic [count_width_p-1:0]   thresh_q, thresh_d;
   logic [timer_width_p-1:0]   timeout_q, timeout_d;
   eth_intr_state_e            state_q, state_d;
   logic [count_width_p-1:0]   cnt_q, cnt_d;
   logic [timer_width_p-1:0]   timer_q, timer_d;
   logic                       src_r_q;
   logic                       pending_q, pending_d;

   logic                       ev;
   logic                       disable_wr;
   logic                       kill;
   logic                       thr_one;
   logic                       hit_thr;
   logic                       hit_to;
   logic [count_width_p-1:0]   cnt_inc;
   logic [timer_width_p-1:0]   timer_inc;
   logic [count_width_p:0]     cnt_sum;
   logic [timer_width_p:0]     timer_sum;

   assign cfg_sel    = eth_intr_cfg_sel_e'(cfg_sel_i);
   assign ev         = enable_q & mode_q & src_i & ~src_r_q;
   assign disable_wr = cfg_we_i && (cfg_sel == ENABLE) && !cfg_data_i[0];
   // Any write that flips the mode abandons whatever the channel was doing.
   assign kill       = disable_wr || (cfg_we_i && (cfg_sel == MODE) && (cfg_data_i[0] != mode_q));
   assign thr_one    = (thresh_q == count_width_p'(1));
   assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + count_width_p'(1);
   assign timer_inc  = (timer_q == '1) ? timer_q : timer_q + timer_width_p'(1);
   assign cnt_sum    = {1'b0, cnt_q} + {{count_width_p{1'b0}}, ev};
   assign timer_sum  = {1'b0, timer_q} + (timer_width_p + 1)'(1);
   assign hit_thr    = (cnt_sum >= {1'b0, thresh_q});
   // Widened compare: a saturated timer never aliases back onto a small timeout.
   assign hit_to     = (timeout_q != '0) && (timer_sum == {1'b0, timeout_q});

   always_comb begin
      enable_d  = enable_q;
      mode_d    = mode_q;
      thresh_d  = thresh_q;
      timeout_d = timeout_q;
      if (cfg_we_i) begin
         case (cfg_sel)
            ENABLE:    enable_d  = cfg_data_i[0];
            MODE:      mode_d    = cfg_data_i[0];
            THRESHOLD: thresh_d  = (cfg_data_i[count_width_p-1:0] == '0) ?
                                   count_width_p'(1) : cfg_data_i[count_width_p-1:0];
            TIMEOUT:   timeout_d = cfg_data_i;
            default:   ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (ev) begin
               cnt_d   = count_width_p'(1);
               timer_d = '0;
               state_d = thr_one ? PENDING : COALESCE;
            end
         end
         COALESCE: begin
            timer_d = timer_inc;
            if (ev) cnt_d = cnt_inc;
            if (hit_thr || hit_to) state_d = PENDING;
         end
         PENDING: begin
            if (clear_i) begin
               cnt_d   = '0;
               timer_d = '0;
               state_d = IDLE;
               // A coincident edge re-arms as a fresh event.
               if (ev) begin
                  cnt_d   = count_width_p'(1);
                  state_d = thr_one ? PENDING : COALESCE;
               end
            end else if (ev) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d = IDLE;
         cnt_d   = '0;
         timer_d = '0;
      end
      pending_d = mode_q ? (state_d == PENDING) : (enable_q & src_i);
      if (kill) pending_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         enable_q  <= enable_rst_lp;
         mode_q    <= mode_rst_lp;
         thresh_q  <= count_width_p'(threshold_rst_lp);
         timeout_q <= timer_width_p'(timeout_rst_lp);
         state_q   <= IDLE;
         cnt_q     <= '0;
         timer_q   <= '0;
         src_r_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         thresh_q  <= thresh_d;
         timeout_q <= timeout_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         src_r_q   <= src_i;
         pending_q <= pending_d;
      end
   end

   assign pending_o     = pending_q;
   assign pending_nxt_o = pending_d;

`ifdef ETH_INTR_STATS_EN
   logic [stat_width_lp-1:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if (pending_d && !pending_q && (stat_q != '1)) stat_d = stat_q + stat_width_lp'(1);
      if (disable_wr) stat_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) stat_q <= '0;
      else         stat_q <= stat_d;
   end

   assign stat_count_o = stat_q;
`else
   assign stat_count_o = '0;
`endif

endmodule

// File: rtl/eth_intr_coalescer.sv
// rtl/eth_intr_coalescer.sv - N-source interrupt coalescer: config/clear decode, per-channel instances, irq OR
// Optional ETH_INTR_STATS_EN enables per-channel stat_count_o counters.
module eth_intr_coalescer
   import eth_intr_pkg::*;
#(
   parameter int num_src_p     = 2,
   parameter int count_width_p = 8,
   parameter int timer_width_p = 16
) (
   input  logic                                               clk_i,
   input  logic                                               reset_i,
   input  logic [num_src_p-1:0]                               src_i,
   input  logic                                               cfg_v_i,
   input  logic [1:0]                                         cfg_sel_i,
   input  logic [((num_src_p > 1) ? $clog2(num_src_p) : 1)-1:0] cfg_chan_i,
   input  logic [timer_width_p-1:0]                           cfg_data_i,
   input  logic                                               clear_v_i,
   input  logic [num_src_p-1:0]                               clear_mask_i,
   output logic [num_src_p-1:0]                               pending_o,
   output logic                                               irq_o,
   output logic [num_src_p*stat_width_lp-1:0]                 stat_count_o
);

   localparam int chan_w_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;

   logic [num_src_p-1:0] pending_nxt;
   logic                 irq_q;

   for (genvar c = 0; c < num_src_p; c++) begin : g_chan
      // Out-of-range channel numbers match no instance and are dropped here.
      logic cfg_we;
      assign cfg_we = cfg_v_i && (cfg_chan_i == chan_w_lp'(c));

      eth_intr_channel #(
         .count_width_p (count_width_p),
         .timer_width_p (timer_width_p)
      ) u_chan (
         .clk_i         (clk_i),
         .reset_i       (reset_i),
         .src_i         (src_i[c]),
         .cfg_we_i      (cfg_we),
         .cfg_sel_i     (cfg_sel_i),
         .cfg_data_i    (cfg_data_i),
         .clear_i       (clear_v_i & clear_mask_i[c]),
         .pending_o     (pending_o[c]),
         .pending_nxt_o (pending_nxt[c]),
         .stat_count_o  (stat_count_o[c*stat_width_lp +: stat_width_lp])
      );
   end

   // irq is its own flop fed from next-state pending so it moves on the same edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) irq_q <= 1'b0;
      else         irq_q <= |pending_nxt;
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_eth_intr_coalescer.sv
// tb/tb_eth_intr_coalescer.sv - directed and random stimulus against a behavioural coalescer model
module tb_eth_intr_coalescer;
   import eth_intr_pkg::*;

   localparam int NS  = 3;
   localparam int CW  = 8;
   localparam int TW  = 16;
   localparam int CHW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NS-1:0]   src;
   logic            cfg_v;
   logic [1:0]      cfg_sel;
   logic [CHW-1:0]  cfg_chan;
   logic [TW-1:0]   cfg_data;
   logic            clear_v;
   logic [NS-1:0]   clear_mask;
   logic [NS-1:0]   pending_o;
   logic            irq_o;
   logic [NS*32-1:0] stat_count_o;

   always #5 clk = ~clk;

   eth_intr_coalescer #(
      .num_src_p     (NS),
      .count_width_p (CW),
      .timer_width_p (TW)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .src_i        (src),
      .cfg_v_i      (cfg_v),
      .cfg_sel_i    (cfg_sel),
      .cfg_chan_i   (cfg_chan),
      .cfg_data_i   (cfg_data),
      .clear_v_i    (clear_v),
      .clear_mask_i (clear_mask),
      .pending_o    (pending_o),
      .irq_o        (irq_o),
      .stat_count_o (stat_count_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: per channel, whether an alarm is raised, whether a coalescing window is
   // open, how many edges and cycles that window has seen, and how often it fired.
   bit          m_en[NS], m_mode[NS], m_prev[NS], m_pend[NS], m_open[NS];
   int          m_thr[NS], m_tmo[NS], m_evs[NS], m_age[NS];
   int unsigned m_stat[NS];

   task automatic model_reset();
      for (int c = 0; c < NS; c++) begin
         m_en[c] = 0; m_mode[c] = 0; m_prev[c] = 0; m_pend[c] = 0; m_open[c] = 0;
         m_thr[c] = 1; m_tmo[c] = 0; m_evs[c] = 0; m_age[c] = 0; m_stat[c] = 0;
      end
   endtask

   task automatic open_window(input int c);
      m_evs[c] = 1;
      m_age[c] = 0;
      if (m_thr[c] == 1) m_pend[c] = 1;
      else               m_open[c] = 1;
   endtask

   task automatic model_update();
      for (int c = 0; c < NS; c++) begin
         bit ev, wr, dis, kill, was;
         ev   = m_en[c] && m_mode[c] && src[c] && !m_prev[c];
         wr   = cfg_v && (int'(cfg_chan) == c);
         dis  = wr && (cfg_sel == 2'd0) && !cfg_data[0];
         kill = dis || (wr && (cfg_sel == 2'd1) && (cfg_data[0] != m_mode[c]));
         was  = m_pend[c];
         if (!m_mode[c]) begin
            m_pend[c] = m_en[c] && src[c];
         end else if (m_pend[c]) begin
            if (clear_v && clear_mask[c]) begin
               m_pend[c] = 0;
               if (ev) open_window(c);
            end
         end else if (m_open[c]) begin
            m_age[c]++;
            m_evs[c] += int'(ev);
            if (m_evs[c] >= m_thr[c] || (m_tmo[c] != 0 && m_age[c] == m_tmo[c])) begin
               m_pend[c] = 1;
               m_open[c] = 0;
            end
         end else if (ev) begin
            open_window(c);
         end
         if (kill) begin m_pend[c] = 0; m_open[c] = 0; end
         if (m_pend[c] && !was) m_stat[c]++;
         if (dis) m_stat[c] = 0;
         if (wr) begin
            case (cfg_sel)
               2'd0: m_en[c]   = cfg_data[0];
               2'd1: m_mode[c] = cfg_data[0];
               2'd2: m_thr[c]  = (cfg_data[CW-1:0] == 0) ? 1 : int'(cfg_data[CW-1:0]);
               default: m_tmo[c] = int'(cfg_data);
            endcase
         end
         m_prev[c] = src[c];
      end
   endtask

   task automatic step();
      logic [NS-1:0]    ep;
      logic [NS*32-1:0] es;
      @(posedge clk);
      if (reset) model_reset();
      else       model_update();
      ep = '0;
      es = '0;
      for (int c = 0; c < NS; c++) begin
         ep[c] = m_pend[c];
`ifdef ETH_INTR_STATS_EN
         es[c*32 +: 32] = m_stat[c];
`endif
      end
      #1;
      check("pending", pending_o, ep);
      check("irq", irq_o, |ep);
      check("stat", stat_count_o, es);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cfg(input int chan, input logic [1:0] sel, input int data);
      cfg_v = 1; cfg_chan = CHW'(chan); cfg_sel = sel; cfg_data = TW'(data);
      step();
      cfg_v = 0;
   endtask

   task automatic clr(input logic [NS-1:0] mask);
      clear_v = 1; clear_mask = mask;
      step();
      clear_v = 0;
   endtask

   task automatic edge1(input int n_low);
      src[1] = 1; step();
      src[1] = 0; run(n_low);
   endtask

   int hi, dly, seen;

   initial begin
      reset = 1; src = '0; cfg_v = 0; cfg_sel = '0; cfg_chan = '0; cfg_data = '0;
      clear_v = 0; clear_mask = '0;
      run(3);
      check("rst_pending", pending_o, 0);
      check("rst_irq", irq_o, 0);
      check("rst_stat", stat_count_o, 0);
      reset = 0;
      step();

      // level mode on ch0, clear ignored
      cfg(0, ENABLE, 1);
      src[0] = 1; hi = 0; clear_mask = '1;
      for (int i = 0; i < 5; i++) begin
         clear_v = (i == 2); step(); hi += int'(pending_o[0]);
      end
      clear_v = 0; src[0] = 0;
      for (int i = 0; i < 2; i++) begin step(); hi += int'(pending_o[0]); end
      check("level_hi_cycles", hi, 5);

      // edge mode threshold 3 on ch1
      cfg(1, ENABLE, 1); cfg(1, MODE, 1); cfg(1, THRESHOLD, 3);
      for (int e = 0; e < 3; e++) begin
         src[1] = 1; step();
         if (e == 1) check("thr3_early", pending_o[1], 0);
         if (e == 2) check("thr3_fire", pending_o[1], 1);
         src[1] = 0; run(3);
      end
      clr(3'b010);
      check("thr3_clear", pending_o[1], 0);

      // timeout 20 with threshold 10, then timeout off
      cfg(1, THRESHOLD, 10); cfg(1, TIMEOUT, 20);
      src[1] = 1; step(); src[1] = 0; dly = 0;
      for (int i = 1; i <= 25; i++) begin
         step();
         if (pending_o[1] && dly == 0) dly = i;
      end
      check("timeout_delay", dly, 20);
      clr(3'b010); cfg(1, TIMEOUT, 0);
      src[1] = 1; step(); src[1] = 0; seen = 0;
      for (int i = 0; i < 30; i++) begin step(); seen |= int'(pending_o[1]); end
      check("timeout_off", seen, 0);
      cfg(1, ENABLE, 0); cfg(1, ENABLE, 1);

      // clear coincident with an edge
      cfg(1, THRESHOLD, 1);
      edge1(1);
      src[1] = 1; clear_v = 1; clear_mask = 3'b010; step();
      check("clr_edge_thr1", pending_o[1], 1);
      clear_v = 0; src[1] = 0; step();
      clr(3'b010); cfg(1, THRESHOLD, 2);
      edge1(1);
      src[1] = 1; step();
      check("thr2_fire", pending_o[1], 1);
      src[1] = 0; step();
      src[1] = 1; clear_v = 1; step();
      check("clr_edge_thr2", pending_o[1], 0);
      clear_v = 0; src[1] = 0; step();
      src[1] = 1; step();
      check("thr2_cnt1", pending_o[1], 1);
      src[1] = 0; step();

      // disable mid-coalesce, then re-enable from idle
      clr(3'b010); cfg(1, THRESHOLD, 5);
      edge1(1);
      cfg(1, ENABLE, 0);
      seen = 0;
      for (int e = 0; e < 3; e++) begin
         src[1] = 1; step(); seen |= int'(pending_o[1]);
         src[1] = 0; step(); seen |= int'(pending_o[1]);
      end
      check("disabled_quiet", seen, 0);
      cfg(1, ENABLE, 1);
      for (int e = 0; e < 5; e++) begin
         src[1] = 1; step();
         if (e == 3) check("reen_early", pending_o[1], 0);
         if (e == 4) check("reen_fire", pending_o[1], 1);
         src[1] = 0; step();
      end

      // statistics: four alarms on ch0
      reset = 1; run(2); reset = 0;
      cfg(0, ENABLE, 1); cfg(0, MODE, 1);
      for (int k = 0; k < 4; k++) begin
         src[0] = 1; step(); src[0] = 0; clr(3'b001);
      end
`ifdef ETH_INTR_STATS_EN
      check("stat4", stat_count_o[31:0], 4);
`else
      check("stat4", stat_count_o[31:0], 0);
`endif
      reset = 1; step();
      check("stat_reset", stat_count_o, 0);
      reset = 0; step();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < NS; c++)
            if ($urandom_range(3) == 0) src[c] = ~src[c];
         cfg_v = ($urandom_range(11) == 0);
         cfg_chan = CHW'($urandom_range(3));
         cfg_sel = 2'($urandom_range(3));
         case (cfg_sel)
            2'd0:    cfg_data = TW'($urandom_range(3) != 0);
            2'd1:    cfg_data = TW'($urandom_range(1));
            2'd2:    cfg_data = TW'($urandom_range(4));
            default: cfg_data = TW'($urandom_range(15));
         endcase
         clear_v = ($urandom_range(5) == 0);
         clear_mask = NS'($urandom);
         reset = ($urandom_range(399) == 0);
         step();
      end
      reset = 0; cfg_v = 0; clear_v = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
